// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the fetch unit AXI-Stream master.
// Imported by fetch_unit_skid_fifo and fetch_unit_m00_axis.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_STREAM,
    ST_DONE
  } state_t;

  localparam int FIFO_DEPTH = 2;
  localparam int OCC_W      = $clog2(FIFO_DEPTH + 1);

  // Sliced down to the stream's byte count by the top.
  localparam logic [127:0] STRB_ONES = '1;

endpackage

// File: rtl/fetch_unit_skid_fifo.sv
// Two-entry {last, data} FIFO buffering BRAM read returns ahead of the stream.
// Occupancy is exported so the reader can apply read credits.
import fetch_unit_pkg::*;

module fetch_unit_skid_fifo #(
  parameter int DW = 32
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [DW-1:0]    i_push_data,
  input  logic             i_push_last,
  input  logic             i_pop,
  output logic             o_empty,
  output logic [DW-1:0]    o_head_data,
  output logic             o_head_last,
  output logic [OCC_W-1:0] o_count
);

  logic [DW:0]      r_mem [FIFO_DEPTH];
  logic             r_wr;
  logic             r_rd;
  logic [OCC_W-1:0] r_cnt;
  logic             w_pop;

  assign w_pop = i_pop && (r_cnt != '0);

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr] <= {i_push_last, i_push_data};
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_wr  <= 1'b0;
      r_rd  <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (i_push) begin
        r_wr <= ~r_wr;
      end
      if (w_pop) begin
        r_rd <= ~r_rd;
      end
      unique case ({i_push, w_pop})
        2'b10:   r_cnt <= r_cnt + OCC_W'(1);
        2'b01:   r_cnt <= r_cnt - OCC_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_empty     = (r_cnt == '0);
  assign o_head_data = r_mem[r_rd][DW-1:0];
  assign o_head_last = r_mem[r_rd][DW];
  assign o_count     = r_cnt;

endmodule

// File: rtl/fetch_unit_m00_axis.sv
// Fetch unit AXI4-Stream master: streams res_size BRAM words as one packet.
// Define FETCH_UNIT_ASSERT_EN to compile in simulation assertions.
import fetch_unit_pkg::*;

module fetch_unit_m00_axis #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int C_M_START_COUNT      = 32,
  parameter int BRAM_DEPTH           = 10
) (
  input  logic                              M_AXIS_ACLK,
  input  logic                              M_AXIS_ARESET,
  input  logic                              VALID_PE2FU,
  input  logic [31:0]                       res_size,
  output logic [BRAM_DEPTH-1:0]             mat_res_addr,
  output logic                              mat_res_ren,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   mat_res_dout,
  output logic                              M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY
);

  localparam int DW = C_M_AXIS_TDATA_WIDTH;
  localparam logic [31:0] START_M1 =
    (C_M_START_COUNT > 0) ? 32'(C_M_START_COUNT - 1) : 32'd0;

  state_t                r_state;
  logic [31:0]           r_init_cnt;
  logic [31:0]           r_remaining;
  logic [BRAM_DEPTH-1:0] r_rd_ptr;
  logic                  r_inflight;
  logic                  r_inflight_last;

  logic                  w_empty;
  logic [DW-1:0]         w_head_data;
  logic                  w_head_last;
  logic [OCC_W-1:0]      w_occ;
  logic                  w_pop;
  logic                  w_ren;
  logic [OCC_W:0]        w_load;

  assign w_pop  = !w_empty && M_AXIS_TREADY;

  // Slots that will be occupied next cycle if nothing new is read.
  assign w_load = {1'b0, w_occ}
                + {{OCC_W{1'b0}}, r_inflight}
                - {{OCC_W{1'b0}}, w_pop};

  assign w_ren  = (r_state == ST_STREAM)
               && (r_remaining != 32'd0)
               && (w_load < (OCC_W+1)'(FIFO_DEPTH));

  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      r_state         <= ST_INIT;
      r_init_cnt      <= 32'd0;
      r_remaining     <= 32'd0;
      r_rd_ptr        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= w_ren;
      r_inflight_last <= w_ren && (r_remaining == 32'd1);
      if (w_ren) begin
        r_rd_ptr    <= r_rd_ptr + BRAM_DEPTH'(1);
        r_remaining <= r_remaining - 32'd1;
      end
      unique case (r_state)
        ST_INIT: begin
          if (r_init_cnt >= START_M1) begin
            r_state <= ST_IDLE;
          end else begin
            r_init_cnt <= r_init_cnt + 32'd1;
          end
        end
        ST_IDLE: begin
          if (VALID_PE2FU) begin
            r_remaining <= res_size;
            r_rd_ptr    <= '0;
            r_state     <= (res_size == 32'd0) ? ST_DONE : ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (w_pop && w_head_last) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!VALID_PE2FU) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  fetch_unit_skid_fifo #(
    .DW (DW)
  ) u_fifo (
    .clk         (M_AXIS_ACLK),
    .i_rst       (M_AXIS_ARESET),
    .i_push      (r_inflight),
    .i_push_data (mat_res_dout),
    .i_push_last (r_inflight_last),
    .i_pop       (w_pop),
    .o_empty     (w_empty),
    .o_head_data (w_head_data),
    .o_head_last (w_head_last),
    .o_count     (w_occ)
  );

  assign mat_res_ren   = w_ren;
  assign mat_res_addr  = r_rd_ptr;
  assign M_AXIS_TVALID = !w_empty;
  assign M_AXIS_TDATA  = w_empty ? '0 : w_head_data;
  assign M_AXIS_TLAST  = !w_empty && w_head_last;
  assign M_AXIS_TSTRB  = STRB_ONES[DW/8-1:0];

`ifdef FETCH_UNIT_ASSERT_EN
  logic [31:0] r_beats;
  logic [31:0] r_size;

  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      r_beats <= 32'd0;
      r_size  <= 32'd0;
    end else if (r_state == ST_IDLE && VALID_PE2FU) begin
      r_beats <= 32'd0;
      r_size  <= res_size;
    end else if (w_pop) begin
      r_beats <= r_beats + 32'd1;
    end
  end

  a_stable: assert property (@(posedge M_AXIS_ACLK)
    disable iff (M_AXIS_ARESET)
    (M_AXIS_TVALID && !M_AXIS_TREADY) |=>
      (M_AXIS_TVALID && $stable(M_AXIS_TDATA) && $stable(M_AXIS_TLAST)));

  a_ren_state: assert property (@(posedge M_AXIS_ACLK)
    mat_res_ren |-> (r_state == ST_STREAM));

  a_no_ovf: assert property (@(posedge M_AXIS_ACLK)
    disable iff (M_AXIS_ARESET)
    (r_inflight && !w_pop) |-> (w_occ < OCC_W'(FIFO_DEPTH)));

  a_beats: assert property (@(posedge M_AXIS_ACLK)
    disable iff (M_AXIS_ARESET)
    (w_pop && w_head_last) |-> ((r_beats + 32'd1) == r_size));
`endif

endmodule

// File: tb/tb_fetch_unit_m00_axis.sv
// Directed bench for fetch_unit_m00_axis with a 1-cycle-latency BRAM model.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_fetch_unit_m00_axis;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [31:0] size;
  logic [9:0]  addr;
  logic        ren;
  logic [31:0] dout;
  logic        tvalid;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic        tlast;
  logic        tready;

  logic [31:0] mem [1024];

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] q_data[$];
  logic        q_last[$];
  int          g_first_valid, g_first_ren, g_last_c, g_ren_cnt;
  int          g_stalls, g_unstable, g_strb_bad, g_zero_bad;
  logic [9:0]  g_first_addr;
  bit          g_done;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ren) dout <= mem[addr];
  end

  fetch_unit_m00_axis dut (
    .M_AXIS_ACLK   (clk),
    .M_AXIS_ARESET (rst),
    .VALID_PE2FU   (valid),
    .res_size      (size),
    .mat_res_addr  (addr),
    .mat_res_ren   (ren),
    .mat_res_dout  (dout),
    .M_AXIS_TVALID (tvalid),
    .M_AXIS_TDATA  (tdata),
    .M_AXIS_TSTRB  (tstrb),
    .M_AXIS_TLAST  (tlast),
    .M_AXIS_TREADY (tready)
  );

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      valid  = 1'b0;
      tready = 1'b1;
    end
  endtask

  // Start a packet in the next cycle and record everything it produces.
  // pat[c] is TREADY in cycle c after the start edge.
  task automatic collect(input logic [31:0] n, input logic [63:0] pat,
                         input bit keep_valid, input int max_c);
    logic [31:0] pd;
    logic        pl;
    bit          prev_stall;
    q_data.delete();
    q_last.delete();
    g_first_valid = -1; g_first_ren = -1; g_last_c = -1;
    g_ren_cnt = 0; g_stalls = 0; g_unstable = 0;
    g_strb_bad = 0; g_zero_bad = 0; g_done = 0;
    g_first_addr = '1;
    prev_stall = 0; pd = '0; pl = 1'b0;
    @(posedge clk); #1;
    valid = 1'b1; size = n; tready = 1'b0;
    for (int c = 1; c <= max_c && !g_done; c++) begin
      @(posedge clk); #1;
      if (!keep_valid) valid = 1'b0;
      tready = pat[c];
      @(negedge clk);
      if (ren) begin
        if (g_first_ren < 0) begin
          g_first_ren  = c;
          g_first_addr = addr;
        end
        g_ren_cnt++;
      end
      if (prev_stall && (!tvalid || tdata !== pd || tlast !== pl))
        g_unstable++;
      if (tvalid && g_first_valid < 0) g_first_valid = c;
      if (tvalid && tstrb !== 4'hF) g_strb_bad++;
      if (!tvalid && tdata !== 32'h0) g_zero_bad++;
      if (tvalid && !tready) g_stalls++;
      if (tvalid && tready) begin
        q_data.push_back(tdata);
        q_last.push_back(tlast);
        g_last_c = c;
        if (tlast) g_done = 1;
      end
      prev_stall = tvalid && !tready;
      pd = tdata;
      pl = tlast;
    end
  endtask

  task automatic test_reset();
    bit done;
    rst = 1'b1; valid = 1'b1; size = 32'd8; tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({tvalid, tlast, ren} !== 3'b000) begin
      n_bad++;
      $display("FAIL rst_ctrl: got %b want 000", {tvalid, tlast, ren});
    end
    n_cmp++;
    if (tdata !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_tdata: got %h want 0", tdata);
    end
    n_cmp++;
    if (addr !== 10'h0) begin
      n_bad++;
      $display("FAIL rst_addr: got %h want 0", addr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      @(negedge clk);
      n_cmp++;
      if (ren !== 1'b0 || tvalid !== 1'b0) begin
        n_bad++;
        $display("FAIL init_quiet[%0d]: got ren=%b tvalid=%b want 0 0",
                 c, ren, tvalid);
      end
    end
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ren !== 1'b1 || addr !== 10'h0) begin
      n_bad++;
      $display("FAIL init_first_ren: got ren=%b addr=%h want 1 0", ren, addr);
    end
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (tvalid && tready && tlast) done = 1;
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL init_drain: got no TLAST want TLAST within 40 cycles");
    end
    idle(3);
  endtask

  task automatic test_stream();
    collect(32'd8, '1, 0, 30);
    n_cmp++;
    if (q_data.size() != 8) begin
      n_bad++;
      $display("FAIL stream_beats: got %0d want 8", q_data.size());
    end
    for (int i = 0; i < 8; i++) begin
      logic [31:0] gd;
      logic        gl;
      gd = (i < q_data.size()) ? q_data[i] : 'x;
      gl = (i < q_last.size()) ? q_last[i] : 1'bx;
      n_cmp++;
      if (gd !== 32'hA0 + i || gl !== (i == 7)) begin
        n_bad++;
        $display("FAIL stream_beat[%0d]: got %h/%b want %h/%b",
                 i, gd, gl, 32'hA0 + i, (i == 7));
      end
    end
    n_cmp++;
    if (g_first_valid != 3) begin
      n_bad++;
      $display("FAIL stream_latency: got %0d want 3", g_first_valid);
    end
    n_cmp++;
    if (g_last_c != 10) begin
      n_bad++;
      $display("FAIL stream_last_cycle: got %0d want 10", g_last_c);
    end
    n_cmp++;
    if (g_first_ren != 1 || g_first_addr !== 10'h0) begin
      n_bad++;
      $display("FAIL stream_first_ren: got c=%0d addr=%h want c=1 addr=0",
               g_first_ren, g_first_addr);
    end
    n_cmp++;
    if (g_ren_cnt != 8) begin
      n_bad++;
      $display("FAIL stream_reads: got %0d want 8", g_ren_cnt);
    end
    n_cmp++;
    if (g_strb_bad != 0 || g_zero_bad != 0) begin
      n_bad++;
      $display("FAIL stream_strb_zero: got %0d/%0d want 0/0",
               g_strb_bad, g_zero_bad);
    end
    idle(3);
  endtask

  task automatic test_backpressure();
    collect(32'd8, 64'hFFFF_FFFF_FFFF_FEF9, 0, 40);
    n_cmp++;
    if (q_data.size() != 8) begin
      n_bad++;
      $display("FAIL bp_beats: got %0d want 8", q_data.size());
    end
    for (int i = 0; i < 8; i++) begin
      logic [31:0] gd;
      logic        gl;
      gd = (i < q_data.size()) ? q_data[i] : 'x;
      gl = (i < q_last.size()) ? q_last[i] : 1'bx;
      n_cmp++;
      if (gd !== 32'hA0 + i || gl !== (i == 7)) begin
        n_bad++;
        $display("FAIL bp_beat[%0d]: got %h/%b want %h/%b",
                 i, gd, gl, 32'hA0 + i, (i == 7));
      end
    end
    n_cmp++;
    if (g_unstable != 0) begin
      n_bad++;
      $display("FAIL bp_stable: got %0d unstable cycles want 0", g_unstable);
    end
    n_cmp++;
    if (g_stalls != 1 || g_last_c != 11) begin
      n_bad++;
      $display("FAIL bp_timing: got stalls=%0d last=%0d want 1 11",
               g_stalls, g_last_c);
    end
    n_cmp++;
    if (g_ren_cnt != 8) begin
      n_bad++;
      $display("FAIL bp_reads: got %0d want 8", g_ren_cnt);
    end
    idle(3);
  endtask

  task automatic test_zero_size();
    int act;
    act = 0;
    @(posedge clk); #1;
    valid = 1'b1; size = 32'd0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == 2) size = 32'd8;
      @(negedge clk);
      if (ren || tvalid) act++;
    end
    n_cmp++;
    if (act != 0) begin
      n_bad++;
      $display("FAIL zero_size_quiet: got %0d active cycles want 0", act);
    end
    idle(3);
  endtask

  task automatic test_hold_level();
    int act;
    collect(32'd8, '1, 1, 30);
    n_cmp++;
    if (!g_done || q_data.size() != 8) begin
      n_bad++;
      $display("FAIL hold_first: got done=%0d beats=%0d want 1 8",
               g_done, q_data.size());
    end
    act = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      valid = 1'b1;
      @(negedge clk);
      if (ren || tvalid) act++;
    end
    n_cmp++;
    if (act != 0) begin
      n_bad++;
      $display("FAIL hold_no_repeat: got %0d active cycles want 0", act);
    end
    @(posedge clk); #1;
    valid = 1'b0;
    collect(32'd8, '1, 0, 30);
    n_cmp++;
    if (q_data.size() != 8 || g_first_valid != 3) begin
      n_bad++;
      $display("FAIL hold_second: got beats=%0d lat=%0d want 8 3",
               q_data.size(), g_first_valid);
    end
    for (int i = 0; i < 8; i++) begin
      logic [31:0] gd;
      gd = (i < q_data.size()) ? q_data[i] : 'x;
      n_cmp++;
      if (gd !== 32'hA0 + i) begin
        n_bad++;
        $display("FAIL hold_beat[%0d]: got %h want %h", i, gd, 32'hA0 + i);
      end
    end
    idle(3);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    valid = 1'b1; size = 32'd8; tready = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      valid = 1'b0;
      @(negedge clk);
    end
    n_cmp++;
    if (tvalid !== 1'b1 || tdata !== 32'hA2) begin
      n_bad++;
      $display("FAIL mid_beat3: got %b/%h want 1/a2", tvalid, tdata);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (tvalid !== 1'b0 || ren !== 1'b0 || tdata !== 32'h0) begin
      n_bad++;
      $display("FAIL mid_reset: got tvalid=%b ren=%b tdata=%h want 0 0 0",
               tvalid, ren, tdata);
    end
    idle(40);
    collect(32'd8, '1, 0, 30);
    n_cmp++;
    if (g_first_addr !== 10'h0 || q_data.size() != 8) begin
      n_bad++;
      $display("FAIL mid_restart: got addr=%h beats=%0d want 0 8",
               g_first_addr, q_data.size());
    end
    for (int i = 0; i < 8; i++) begin
      logic [31:0] gd;
      gd = (i < q_data.size()) ? q_data[i] : 'x;
      n_cmp++;
      if (gd !== 32'hA0 + i) begin
        n_bad++;
        $display("FAIL mid_beat[%0d]: got %h want %h", i, gd, 32'hA0 + i);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA0 + i;
    dout = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_zero_size();
    test_hold_level();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
